stream_window_gen: RTL
======================

Name: stream_window_gen

Overview:
- AXI4-Stream video window generator; the parametrised front end for the next-generation convolution filter.
- Buffers WIN_DIM-1 video lines and emits, for every accepted input pixel, the full WIN_DIM x WIN_DIM neighbourhood ending at that pixel.
- Generalised in channel count, channel width and window size, with a selectable zero-fill border mode.
- The downstream MAC/normalise stage consumes the window directly.

Parameters:
- WIN_DIM, 3, window side K (odd, 3..7).
- CHANNELS, 3, colour channels per pixel.
- DATA_WIDTH, 8, bits per channel; PIX_W = CHANNELS*DATA_WIDTH.
- MAX_IMG_RES, 1920, maximum pixels per line (line RAM depth).
- BORDER_MODE, 1, 0 = raw (stale line-RAM/shift contents at borders), 1 = zero-fill out-of-frame taps.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_axis_video_tdata  in  PIX_W  input pixel.
- s_axis_video_tvalid  in  1  input valid.
- s_axis_video_tready  out  1  input ready.
- s_axis_video_tuser  in  1  start of frame.
- s_axis_video_tlast  in  1  end of line.
- m_axis_video_tdata  out  K*K*PIX_W  window; tap (r,c) at bits [(r*K+c)*PIX_W +: PIX_W]; r=0 oldest row, c=0 leftmost column, (K-1,K-1) = current pixel.
- m_axis_video_tvalid  out  1  output valid.
- m_axis_video_tready  in  1  output ready.
- m_axis_video_tuser  out  1  SOF, aligned with the current pixel.
- m_axis_video_tlast  out  1  EOL, aligned with the current pixel.
- m_axis_video_tfull  out  1  1 when every tap lies inside the frame (row >= K-1 and col >= K-1).
- line_overflow  out  1  sticky flag: a line exceeded MAX_IMG_RES.

Behaviour:
- Reset (async, active-high): m_axis_video_tvalid, tuser, tlast and tfull = 0; tdata = 0; line_overflow = 0; row/col counters = 0; window shift registers = 0. Line RAM contents are not cleared.
- Handshake: single registered output stage. s_axis_video_tready = !m_axis_video_tvalid || m_axis_video_tready. A pixel is accepted on s_valid && s_ready.
- Latency: the window for pixel N is valid on the cycle after N is accepted.
- Output holds stable while m_valid && !m_ready. m_valid drops after a transfer with no new input accepted.
- Counters (x = col, y = row):
  - An accept with tuser=1 forces the effective position to x=0, y=0 for that pixel, regardless of the prior state (mid-frame SOF restarts the frame).
  - After an accept with tlast=1: x <= 0, y <= min(y+1, K-1) (saturating).
  - Otherwise: x <= x+1.
- Line RAM: K-1 lines, addressed by x, combinational read (LUTRAM/behavioural). On accept at column x:
  - Read taps L[j][x], j = 0..K-2, where L[0] is the previous row.
  - Write L[0][x] <= pixel and L[j][x] <= L[j-1][x] (cascade).
- Window update: each row shifts left by one column. The new right column is rows r = 0..K-2 from L[K-2-r][x], and row K-1 from the input pixel.
- Zero-fill (BORDER_MODE=1), applied to the registered output only:
  - Tap (r,c) is forced to 0 when y < K-1-r or x < K-1-c.
  - The shift state keeps the raw data.
  - BORDER_MODE=0 passes raw taps.
- tfull = (y >= K-1) && (x >= K-1), with y saturated.
- Overflow: if x reaches MAX_IMG_RES-1 without tlast, x saturates. Further pixels overwrite the last address and line_overflow is set. line_overflow clears only on reset or an accepted SOF.
- tuser and tlast pass through aligned with the pixel. tlast needs no flush: the block emits exactly one output beat per input beat.
- Simultaneous tuser and tlast on one beat (1-pixel line): x=0, y=0 for that pixel, then next y=1.
- Reset mid-frame: the block restarts cleanly. The next frame must begin with SOF; before that SOF, y starts at 0.

Test Plan:
- K=3, CHANNELS=3, DATA_WIDTH=8, MAX_IMG_RES=16, BORDER_MODE=1; 4x4 frame, pixel value = 0x010101*(y*4+x+1), m_ready=1 -> output (y=0,x=0) has tap(2,2)=0x010101 and all others 0. Output (2,2) has tfull=1, tap(0,0)=0x010101, tap(2,2)=0x0B0B0B.
- Same frame with m_ready toggled 1,0,0,1 each cycle -> exactly 16 output beats; tdata stable while stalled; s_ready=0 during stall.
- Mid-frame SOF after 6 pixels -> the next output has tuser=1 and tfull=0; taps outside row 2 are zero; the old rows never appear in zero-filled taps.
- BORDER_MODE=0, second frame identical to the first -> output (0,0) tap(1,2) equals the stale last-row data (0x0D0D0D); tfull=0.
- 18-pixel line with tlast only on the 18th pixel -> line_overflow=1 from the 17th accepted beat; it stays 1 until the next accepted SOF and is then 0.
- Assert reset mid-line during a stall -> all outputs are 0 on the same cycle; after release, a new 4x4 frame reproduces scenario 1 exactly.

Source files
------------

// File: rtl/stream_window_gen.sv
// stream_window_gen: AXI4-Stream video window generator. Buffers WIN_DIM-1
// lines and emits, per accepted pixel, the WIN_DIM x WIN_DIM neighbourhood.
// Ports: clk, reset (async, active-high); s_axis_video_* pixel input
// (tdata/tvalid/tready/tuser=SOF/tlast=EOL); m_axis_video_* window output
// (tdata = K*K taps, tap (r,c) at [(r*K+c)*PIX_W +: PIX_W], tfull = all taps
// in frame); line_overflow = sticky, a line exceeded MAX_IMG_RES pixels.
module stream_window_gen #(
    parameter int WIN_DIM     = 3,
    parameter int CHANNELS    = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_IMG_RES = 1920,
    parameter int BORDER_MODE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_video_tdata,
    input  logic s_axis_video_tvalid,
    output logic s_axis_video_tready,
    input  logic s_axis_video_tuser,
    input  logic s_axis_video_tlast,
    output logic [WIN_DIM*WIN_DIM*CHANNELS*DATA_WIDTH-1:0] m_axis_video_tdata,
    output logic m_axis_video_tvalid,
    input  logic m_axis_video_tready,
    output logic m_axis_video_tuser,
    output logic m_axis_video_tlast,
    output logic m_axis_video_tfull,
    output logic line_overflow
);
    localparam int K     = WIN_DIM;
    localparam int PIX_W = CHANNELS * DATA_WIDTH;
    localparam int XW    = (MAX_IMG_RES > 1) ? $clog2(MAX_IMG_RES) : 1;
    localparam int YW    = $clog2(K);

    logic [XW-1:0] x_q, x_d, xe;
    logic [YW-1:0] y_q, y_d, ye;
    logic xs_q, xs_d;
    logic ovf_q, ovf_d;
    logic valid_q, valid_d;
    logic user_q, user_d;
    logic last_q, last_d;
    logic full_q, full_d;
    logic [K*K*PIX_W-1:0] odata_q, odata_d;
    logic [PIX_W-1:0] win_q [K][K];
    logic [PIX_W-1:0] win_d [K][K];
    logic [PIX_W-1:0] mem [K-1][MAX_IMG_RES];
    logic [PIX_W-1:0] rd [K-1];
    logic acc;
    int yi, xi;

    assign s_axis_video_tready = !valid_q || m_axis_video_tready;
    assign acc = s_axis_video_tvalid && s_axis_video_tready;

    assign m_axis_video_tdata  = odata_q;
    assign m_axis_video_tvalid = valid_q;
    assign m_axis_video_tuser  = user_q;
    assign m_axis_video_tlast  = last_q;
    assign m_axis_video_tfull  = full_q;
    assign line_overflow       = ovf_q;

    always_comb begin
        // SOF restarts the frame at (0,0) for the pixel carrying it
        xe = s_axis_video_tuser ? '0 : x_q;
        ye = s_axis_video_tuser ? '0 : y_q;
        yi = 32'(ye);
        xi = 32'(xe);
        for (int j = 0; j < K - 1; j++) rd[j] = mem[j][xe];
        x_d     = x_q;
        y_d     = y_q;
        xs_d    = xs_q;
        ovf_d   = ovf_q;
        win_d   = win_q;
        odata_d = odata_q;
        full_d  = full_q;
        user_d  = user_q;
        last_d  = last_q;
        valid_d = m_axis_video_tready ? 1'b0 : valid_q;
        if (acc) begin
            valid_d = 1'b1;
            user_d  = s_axis_video_tuser;
            last_d  = s_axis_video_tlast;
            full_d  = (ye == YW'(K - 1)) && (xe >= XW'(K - 1));
            y_d     = ye;
            if (s_axis_video_tuser) ovf_d = 1'b0;
            // xs_q marks that x already sat at the last address
            if (xs_q && !s_axis_video_tuser) ovf_d = 1'b1;
            if (s_axis_video_tlast) begin
                x_d  = '0;
                xs_d = 1'b0;
                y_d  = (ye == YW'(K - 1)) ? ye : ye + 1'b1;
            end else if (xe == XW'(MAX_IMG_RES - 1)) begin
                x_d  = xe;
                xs_d = 1'b1;
            end else begin
                x_d  = xe + 1'b1;
                xs_d = 1'b0;
            end
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K - 1; c++)
                    win_d[r][c] = win_q[r][c+1];
            // row 0 is the oldest line, fed from the deepest line buffer
            for (int r = 0; r < K - 1; r++)
                win_d[r][K-1] = rd[K-2-r];
            win_d[K-1][K-1] = s_axis_video_tdata;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    if (BORDER_MODE != 0 && (yi < K - 1 - r || xi < K - 1 - c))
                        odata_d[(r*K+c)*PIX_W +: PIX_W] = '0;
                    else
                        odata_d[(r*K+c)*PIX_W +: PIX_W] = win_d[r][c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            odata_q <= '0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win_q[r][c] <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            xs_q    <= xs_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            user_q  <= user_d;
            last_q  <= last_d;
            full_q  <= full_d;
            odata_q <= odata_d;
            win_q   <= win_d;
        end
    end

    // line buffers cascade one line deeper on every write
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[0][xe] <= s_axis_video_tdata;
            for (int j = 1; j < K - 1; j++)
                mem[j][xe] <= rd[j-1];
        end
    end
endmodule
